// File: rtl/fwd_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit_pkg
//   Shared definitions for the forwarding / hazard unit.
//   - fwd_sel_e : ALU operand source select. The EX-stage operand mux decodes
//                 the same encoding (00 regfile, 10 EX/MEM result, 01 MEM/WB data).
//   - Default widths for the register number and the statistics counters.
// -----------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

  localparam int REG_AW_DEFAULT = 5;
  localparam int STAT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // operand from the register file
    FWD_WB  = 2'b01,  // operand from MEM/WB (WB_WriteRegData)
    FWD_MEM = 2'b10   // operand from EX/MEM (MEM_ALUResult)
  } fwd_sel_e;

endpackage : fwd_hazard_unit_pkg

// File: rtl/fwd_hazard_unit_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Combinational forwarding-select for one source operand, evaluated while
//   the consumer is in ID.
//   Ports:
//     src     in  REG_AW  source register number read by the ID instruction
//     ex_dst  in  REG_AW  destination of the instruction currently in EX
//     ex_we   in  1       instruction in EX writes the register file
//     mem_dst in  REG_AW  destination held in the EX/MEM shadow slot
//     mem_we  in  1       EX/MEM shadow slot writes the register file
//     sel     out 2       FWD_MEM / FWD_WB / FWD_REG
//   The EX producer is checked first so the newest value wins when both
//   producers target the same register. Register 0 is never forwarded.
// -----------------------------------------------------------------------------
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_we,
  output fwd_sel_e          sel
);

  logic src_live;

  assign src_live = (src != '0);

  always_comb begin
    // NOTE: default assigned first so every path drives sel; otherwise a latch is inferred.
    sel = FWD_REG;
    if (src_live && ex_we && (ex_dst == src)) begin
      sel = FWD_MEM;
    end else if (src_live && mem_we && (mem_dst == src)) begin
      sel = FWD_WB;
    end
  end

endmodule : fwd_select

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding selects for the EX-stage ALU operand muxes plus load-use stall
//   and taken-branch flush controls.
//   A shadow pipeline of (dst, we) pairs mirrors the EX/MEM and MEM/WB slots.
//   Selects are computed in ID and registered, so they are valid at the start
//   of the cycle in which the consumer occupies EX.
//
//   Optional feature macro: FWD_HAZ_STATS_EN
//     defined   -> saturating stall / flush counters on HZ_StallCnt / HZ_FlushCnt
//     undefined -> counters not built, both ports tied to 0
//
//   Ports:
//     clk             in   1       pipeline clock, rising edge
//     rst_n           in   1       synchronous active-low reset
//     PL_Hold         in   1       global freeze, all state holds
//     ID_Rs / ID_Rt   in   REG_AW  source registers of the instruction in ID
//     EX_WriteReg     in   REG_AW  destination of the instruction in EX
//     EX_RegWrite     in   1       EX instruction writes the register file
//     EX_MemRead      in   1       EX instruction is a load
//     EX_BranchTaken  in   1       branch resolved taken in EX
//     EX_Forwarding1  out  2       operand A select (from ID_Rs)
//     EX_Forwarding2  out  2       operand B select (from ID_Rt)
//     HZ_Stall        out  1       hold PC and IF/ID, bubble into ID/EX
//     HZ_Flush        out  1       squash IF/ID and ID/EX
//     HZ_StallCnt     out  STAT_W  load-use stalls since reset
//     HZ_FlushCnt     out  STAT_W  flushes since reset
// -----------------------------------------------------------------------------
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int STAT_W = STAT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PL_Hold,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic [REG_AW-1:0] EX_WriteReg,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic              EX_BranchTaken,
  output logic [1:0]        EX_Forwarding1,
  output logic [1:0]        EX_Forwarding2,
  output logic              HZ_Stall,
  output logic              HZ_Flush,
  output logic [STAT_W-1:0] HZ_StallCnt,
  output logic [STAT_W-1:0] HZ_FlushCnt
);

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              we;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  // Two-deep shift register: low slot is EX/MEM, high slot is MEM/WB.
  // The MEM/WB slot is tracked but never forwarded from: the register file is
  // write-first, so a same-cycle WB write is already visible to the ID read.
  logic [2*SLOT_W-1:0] shadow_q;
  slot_t               ex_slot;
  slot_t               mem_slot;

  fwd_sel_e sel_rs;
  fwd_sel_e sel_rt;
  fwd_sel_e fwd1_q;
  fwd_sel_e fwd2_q;

  logic load_use;
  logic bubble;

  assign ex_slot  = '{dst: EX_WriteReg, we: EX_RegWrite};
  assign mem_slot = slot_t'(shadow_q[SLOT_W-1:0]);

  // ---------------------------------------------------------------------------
  // Select precompute for both operands
  // ---------------------------------------------------------------------------
  fwd_select #(.REG_AW(REG_AW)) u_sel_rs (
    .src     (ID_Rs),
    .ex_dst  (EX_WriteReg),
    .ex_we   (EX_RegWrite),
    .mem_dst (mem_slot.dst),
    .mem_we  (mem_slot.we),
    .sel     (sel_rs)
  );

  fwd_select #(.REG_AW(REG_AW)) u_sel_rt (
    .src     (ID_Rt),
    .ex_dst  (EX_WriteReg),
    .ex_we   (EX_RegWrite),
    .mem_dst (mem_slot.dst),
    .mem_we  (mem_slot.we),
    .sel     (sel_rt)
  );

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // A load in EX whose result an ID operand needs: one bubble suffices, since
  // next cycle the load sits in MEM and the select resolves to FWD_WB.
  assign load_use = EX_MemRead && EX_RegWrite && (EX_WriteReg != '0) &&
                    ((EX_WriteReg == ID_Rs) || (EX_WriteReg == ID_Rt));

  // Flush wins over stall: the stalled instruction is squashed anyway.
  // Both are gated off while reset is asserted. They are not gated by hold;
  // consumers qualify them with PL_Hold themselves.
  assign HZ_Flush = rst_n && EX_BranchTaken;
  assign HZ_Stall = rst_n && load_use && !EX_BranchTaken;

  assign bubble = EX_BranchTaken || load_use;

  // ---------------------------------------------------------------------------
  // State: shadow slots and registered selects
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: shadow slots are reset explicitly; a stale we=1 left over from
      // before reset would forward a value that was never produced.
      shadow_q <= '0;
      fwd1_q   <= FWD_REG;
      fwd2_q   <= FWD_REG;
    end else if (!PL_Hold) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      // Shifting the whole vector moves EX -> EX/MEM and EX/MEM -> MEM/WB.
      shadow_q <= (shadow_q << SLOT_W) | {{SLOT_W{1'b0}}, ex_slot};
      if (bubble) begin
        // The bubble reads the register file and writes nothing.
        fwd1_q <= FWD_REG;
        fwd2_q <= FWD_REG;
      end else begin
        fwd1_q <= sel_rs;
        fwd2_q <= sel_rt;
      end
    end
  end

  assign EX_Forwarding1 = fwd1_q;
  assign EX_Forwarding2 = fwd2_q;

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef FWD_HAZ_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!PL_Hold) begin
      // Saturate at all-ones rather than wrapping.
      if (HZ_Stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (HZ_Flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign HZ_StallCnt = stall_cnt_q;
  assign HZ_FlushCnt = flush_cnt_q;
`else
  assign HZ_StallCnt = '0;
  assign HZ_FlushCnt = '0;
`endif

endmodule : fwd_hazard_unit

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Directed bench for fwd_hazard_unit. Inputs change 1 time unit after a
//   rising edge; combinational outputs are sampled before the next edge and
//   registered outputs 1 time unit after it. Counter expectations follow
//   FWD_HAZ_STATS_EN when that macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int REG_AW = 5;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              PL_Hold;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic [REG_AW-1:0] EX_WriteReg;
  logic              EX_RegWrite;
  logic              EX_MemRead;
  logic              EX_BranchTaken;
  logic [1:0]        EX_Forwarding1;
  logic [1:0]        EX_Forwarding2;
  logic              HZ_Stall;
  logic              HZ_Flush;
  logic [STAT_W-1:0] HZ_StallCnt;
  logic [STAT_W-1:0] HZ_FlushCnt;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  fwd_hazard_unit #(.REG_AW(REG_AW), .STAT_W(STAT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PL_Hold        (PL_Hold),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .EX_WriteReg    (EX_WriteReg),
    .EX_RegWrite    (EX_RegWrite),
    .EX_MemRead     (EX_MemRead),
    .EX_BranchTaken (EX_BranchTaken),
    .EX_Forwarding1 (EX_Forwarding1),
    .EX_Forwarding2 (EX_Forwarding2),
    .HZ_Stall       (HZ_Stall),
    .HZ_Flush       (HZ_Flush),
    .HZ_StallCnt    (HZ_StallCnt),
    .HZ_FlushCnt    (HZ_FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [REG_AW-1:0] wr, input logic we,
                       input logic mr, input logic br);
    ID_Rs          = rs;
    ID_Rt          = rt;
    EX_WriteReg    = wr;
    EX_RegWrite    = we;
    EX_MemRead     = mr;
    EX_BranchTaken = br;
  endtask

  initial begin
    // ---------------- reset, with hazards present on the inputs -------------
    rst_n   = 1'b0;
    PL_Hold = 1'b0;
    drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1);
    #2;
    check("rst_stall_gated", {31'd0, HZ_Stall}, 32'd0);
    check("rst_flush_gated", {31'd0, HZ_Flush}, 32'd0);
    tick();
    check("rst_fwd1", {30'd0, EX_Forwarding1}, {30'd0, SEL_REG});
    check("rst_fwd2", {30'd0, EX_Forwarding2}, {30'd0, SEL_REG});
    check("rst_stall_cnt", {16'd0, HZ_StallCnt}, 32'd0);
    check("rst_flush_cnt", {16'd0, HZ_FlushCnt}, 32'd0);
    rst_n = 1'b1;

    // ---------------- 1: EX producer -> FWD_MEM ------------------------------
    drive(5'd3, 5'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    check("t1_stall", {31'd0, HZ_Stall}, 32'd0);
    tick();  // mem slot = {3,1}
    check("t1_fwd1_mem", {30'd0, EX_Forwarding1}, {30'd0, SEL_MEM});
    check("t1_fwd2_reg", {30'd0, EX_Forwarding2}, {30'd0, SEL_REG});

    // ---------------- 2: producer two ahead -> FWD_WB ------------------------
    drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();  // mem slot = {5,1}
    drive(5'd3, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();  // mem slot = {9,1}
    check("t2_fwd2_wb", {30'd0, EX_Forwarding2}, {30'd0, SEL_WB});
    check("t2_fwd1_nomatch", {30'd0, EX_Forwarding1}, {30'd0, SEL_REG});

    // both producers target $5: newest wins
    drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();  // mem slot = {5,1}
    drive(5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    check("t2_fwd1_newest", {30'd0, EX_Forwarding1}, {30'd0, SEL_MEM});
    check("t2_fwd2_newest", {30'd0, EX_Forwarding2}, {30'd0, SEL_MEM});

    // EX/MEM slot matches but does not write -> no forwarding
    drive(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0);
    tick();  // mem slot = {6,0}
    drive(5'd6, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();  // mem slot = {1,1}
    check("t2_mem_we0", {30'd0, EX_Forwarding1}, {30'd0, SEL_REG});

    // ---------------- 3: load-use, one bubble, then FWD_WB -------------------
    drive(5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
    #1;
    check("t3_stall_on", {31'd0, HZ_Stall}, 32'd1);
    check("t3_no_flush", {31'd0, HZ_Flush}, 32'd0);
    tick();  // mem slot = {4,1}
    check("t3_bubble_fwd1", {30'd0, EX_Forwarding1}, {30'd0, SEL_REG});
    check("t3_bubble_fwd2", {30'd0, EX_Forwarding2}, {30'd0, SEL_REG});
    drive(5'd4, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);  // bubble now in EX
    #1;
    check("t3_stall_off", {31'd0, HZ_Stall}, 32'd0);
    tick();  // mem slot = {0,0}
    check("t3_fwd1_wb", {30'd0, EX_Forwarding1}, {30'd0, SEL_WB});

    // ---------------- 4: register 0 never forwarded or stalled ---------------
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    #1;
    check("t4_r0_stall", {31'd0, HZ_Stall}, 32'd0);
    tick();  // mem slot = {0,1}
    check("t4_r0_fwd1", {30'd0, EX_Forwarding1}, {30'd0, SEL_REG});

    // ---------------- 5: flush beats stall -----------------------------------
    drive(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1);
    #1;
    check("t5_flush", {31'd0, HZ_Flush}, 32'd1);
    check("t5_stall_masked", {31'd0, HZ_Stall}, 32'd0);
    tick();  // mem slot = {8,1}
    check("t5_fwd1_squash", {30'd0, EX_Forwarding1}, {30'd0, SEL_REG});

    // ---------------- 6: PL_Hold freezes selects and shadow ------------------
    drive(5'd10, 5'd8, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();  // fwd1=MEM, fwd2=WB, mem slot = {10,1}
    check("t6_pre_fwd1", {30'd0, EX_Forwarding1}, {30'd0, SEL_MEM});
    check("t6_pre_fwd2", {30'd0, EX_Forwarding2}, {30'd0, SEL_WB});
    PL_Hold = 1'b1;
    drive(5'd12, 5'd10, 5'd12, 1'b1, 1'b1, 1'b0);
    #1;
    check("t6_hold_stall_vis", {31'd0, HZ_Stall}, 32'd1);
    tick();
    check("t6_hold1_fwd1", {30'd0, EX_Forwarding1}, {30'd0, SEL_MEM});
    drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check("t6_hold2_fwd2", {30'd0, EX_Forwarding2}, {30'd0, SEL_WB});
    drive(5'd12, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1);
    #1;
    check("t6_hold_flush_vis", {31'd0, HZ_Flush}, 32'd1);
    tick();
    check("t6_hold3_fwd1", {30'd0, EX_Forwarding1}, {30'd0, SEL_MEM});
    check("t6_hold3_fwd2", {30'd0, EX_Forwarding2}, {30'd0, SEL_WB});
    PL_Hold = 1'b0;
    // mem slot must still be {10,1}; had it shifted during hold it would differ
    drive(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t6_shadow_held", {30'd0, EX_Forwarding1}, {30'd0, SEL_WB});
    check("t6_post_fwd2", {30'd0, EX_Forwarding2}, {30'd0, SEL_REG});

    // counters: one stall (step 3), one flush (step 5); held cycles not counted
`ifdef FWD_HAZ_STATS_EN
    check("stall_cnt", {16'd0, HZ_StallCnt}, 32'd1);
    check("flush_cnt", {16'd0, HZ_FlushCnt}, 32'd1);
`else
    check("stall_cnt_tied", {16'd0, HZ_StallCnt}, 32'd0);
    check("flush_cnt_tied", {16'd0, HZ_FlushCnt}, 32'd0);
`endif

    // ---------------- mid-run reset clears selects, shadow and counters ------
    drive(5'd10, 5'd10, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();  // mem slot = {10,1}, fwd1 = MEM
    rst_n = 1'b0;
    tick();
    check("rst2_fwd1", {30'd0, EX_Forwarding1}, {30'd0, SEL_REG});
    check("rst2_fwd2", {30'd0, EX_Forwarding2}, {30'd0, SEL_REG});
    check("rst2_stall_cnt", {16'd0, HZ_StallCnt}, 32'd0);
    check("rst2_flush_cnt", {16'd0, HZ_FlushCnt}, 32'd0);
    rst_n = 1'b1;
    drive(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("rst2_shadow_clear", {30'd0, EX_Forwarding1}, {30'd0, SEL_REG});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fwd_hazard_unit
